nf_dm_resp_unit: RTL and testbench
==================================

# nf_dm_resp_unit

Data-memory responder: the slave end of the memory-stage request/acknowledge handshake that feeds `req_ack_dm` into the core's stall/flush logic. It accepts one load or store request at a time, applies a configurable number of wait states, and drives a byte-enabled single-port synchronous RAM. It returns a one-cycle `req_ack_dm` pulse with right-justified read data or an error flag. Sits between the core's memory stage and the data RAM.

## Interface
- `WAIT_CYCLES`, default 1: wait states inserted before the RAM access, range 0..15.
- `clk`  in  1  system clock, all state updates on rising edge.
- `resetn`  in  1  reset; **one clock; reset is asynchronous and active-low.**
- `req_dm`  in  1  request, held high by the core until `req_ack_dm`.
- `we_dm`  in  1  1 = store, 0 = load.
- `addr_dm`  in  32  byte address.
- `wd_dm`  in  32  store data, right-justified.
- `size_dm`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_ack_dm`  out  1  single-cycle completion pulse.
- `rd_dm`  out  32  load data, right-justified, zero-extended; valid only while `req_ack_dm` = 1, else 0.
- `err_dm`  out  1  misaligned or reserved-size request; valid with `req_ack_dm`.
- `ram_en`  out  1  RAM access strobe.
- `ram_be`  out  4  byte write enables; 0 on reads.
- `ram_addr`  out  32  word-aligned address (`addr[31:2]`, 2'b00).
- `ram_wd`  out  32  lane-replicated write data.
- `ram_rd`  in  32  RAM read data, valid the cycle after `ram_en`.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: when `req_dm` = 1, latch `we`, `addr`, `wd` and `size`, and compute the error.
  - Error: go to RESP with error set.
  - Otherwise, with `WAIT_CYCLES` = 0: go to ACCESS.
  - Otherwise: load the counter with `WAIT_CYCLES - 1` and go to WAIT.
- WAIT: decrement the counter each cycle; at 0, go to ACCESS.
- ACCESS: `ram_en` = 1 for exactly one cycle. `ram_be` is the computed enables only when the latched `we` = 1. Then go to RESP.
- RESP: `req_ack_dm` = 1 for one cycle, then go to IDLE.
  - Load: `rd_dm` is formatted from `ram_rd`.
  - Error: `err_dm` = 1 and `rd_dm` = 0.
- Byte enables:
  - Byte: 4'b0001 shifted left by `addr[1:0]`.
  - Half: 4'b0011 shifted left by `addr[1:0]`; error if `addr[0]` = 1.
  - Word: 4'b1111; error if `addr[1:0]` ≠ 0.
  - Size 3: always an error.
- Write data: byte replicates `wd[7:0]` ×4; half replicates `wd[15:0]` ×2; word is passed through.
- Read format:
  - Byte: the lane selected by `addr[1:0]`, zero-extended.
  - Half: lane pair `addr[1]`, zero-extended.
  - Word: passed through.
  - Sign extension is the core's job.
- All RAM outputs are driven only from latched values. Input changes after sampling are ignored.
- A drop of `req_dm` mid-transaction is ignored. The transaction completes and acknowledges normally.
- Errors never assert `ram_en`. The RAM is untouched.

## Timing
- Reset values: state IDLE, counter 0, `req_ack_dm` 0, `err_dm` 0, `rd_dm` 0, `ram_en` 0, `ram_be` 0, `ram_addr` 0, `ram_wd` 0.
- Reset mid-transaction:
  - Immediate return to IDLE.
  - No acknowledge.
  - An in-flight `ram_en` is deasserted asynchronously.
  - A still-high `req_dm` after `resetn` rises is treated as a new request.
- Latency, counting the sampling edge in IDLE as cycle 0:
  - `ram_en` is high in cycle `WAIT_CYCLES + 1`.
  - `req_ack_dm` is high in cycle `WAIT_CYCLES + 2`.
  - Error acknowledge is in cycle 1.
- Back-to-back: in the cycle after the acknowledge, the block is in IDLE and samples `req_dm`. Minimum request-to-request spacing is `WAIT_CYCLES + 3` cycles (2 for errors).
- Because the acknowledge occurs in RESP, not IDLE, the request still high during the acknowledge cycle is never sampled twice.
- Throughput: one outstanding request, no pipelining.

## Test plan
- Reset, then `WAIT_CYCLES` = 1: word store of 0xDEADBEEF to 0x100.
  - `ram_en` in cycle 2 with `ram_be` = 4'hF, `ram_addr` = 0x100, `ram_wd` = 0xDEADBEEF.
  - `req_ack_dm` in cycle 3 only, `err_dm` = 0.
- Byte load from 0x103 with `ram_rd` = 0xA1B2C3D4 and `WAIT_CYCLES` = 0:
  - `ram_en` in cycle 1 with `ram_be` = 0.
  - Acknowledge in cycle 2 with `rd_dm` = 0x000000A1.
- Half store of `wd` = 0x00001234 to 0x102: `ram_be` = 4'b1100, `ram_wd` = 0x12341234. A half store to 0x101 gives `err_dm` = 1 and an acknowledge in cycle 1 with no `ram_en`.
- `req_dm` held high continuously with 5 word loads and `WAIT_CYCLES` = 3: exactly 5 acknowledges, spaced 6 cycles apart, each preceded by exactly one `ram_en`.
- `resetn` pulsed low during WAIT: all outputs 0 immediately, no acknowledge. With `req_dm` still high, a fresh transaction completes `WAIT_CYCLES + 2` cycles after reset release.
- `addr_dm` and `wd_dm` changed, and `req_dm` dropped, during WAIT: RAM sees the originally latched values and the acknowledge still occurs on schedule.

Source files
------------

// File: rtl/nf_dm_resp_unit.sv
// nf_dm_resp_unit: data-memory responder for the core's memory stage.
// Accepts one load/store at a time, inserts WAIT_CYCLES wait states, drives a
// byte-enabled synchronous RAM and returns a one-cycle acknowledge carrying
// right-justified, zero-extended load data or an error flag.
module nf_dm_resp_unit #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_dm,
    input  logic        we_dm,
    input  logic [31:0] addr_dm,
    input  logic [31:0] wd_dm,
    input  logic [1:0]  size_dm,
    output logic        req_ack_dm,
    output logic [31:0] rd_dm,
    output logic        err_dm,
    output logic        ram_en,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    // Counter preload: WAIT holds for WAIT_CYCLES cycles, counting down to 0.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [3:0]  be_q;

    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        req_err;

    // Decode the live request: lane enables, replicated write data, alignment error.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        req_be  = 4'b0000;
        req_wd  = wd_dm;
        req_err = 1'b0;
        case (size_dm)
            2'd0: begin
                req_be = 4'b0001 << addr_dm[1:0];
                req_wd = {4{wd_dm[7:0]}};
            end
            2'd1: begin
                req_be  = 4'b0011 << addr_dm[1:0];
                req_wd  = {2{wd_dm[15:0]}};
                req_err = addr_dm[0];
            end
            2'd2: begin
                req_be  = 4'b1111;
                req_err = (addr_dm[1:0] != 2'b00);
            end
            default: req_err = 1'b1;
        endcase
    end

    // Handshake FSM: latches the request in IDLE and produces registered RAM/ack strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the request latches are reset along with the FSM, so the RAM pins read 0 rather than stale or unknown values after reset.
            state      <= S_IDLE;
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            lane_q     <= 2'd0;
            be_q       <= 4'b0000;
            ram_addr   <= 32'h0;
            ram_wd     <= 32'h0;
            ram_en     <= 1'b0;
            ram_be     <= 4'b0000;
            req_ack_dm <= 1'b0;
            err_dm     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here; the strobes default low and are raised only in the cycle that needs them.
            ram_en     <= 1'b0;
            ram_be     <= 4'b0000;
            req_ack_dm <= 1'b0;
            err_dm     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_dm) begin
                        we_q     <= we_dm;
                        size_q   <= size_dm;
                        lane_q   <= addr_dm[1:0];
                        be_q     <= req_be;
                        ram_addr <= {addr_dm[31:2], 2'b00};
                        ram_wd   <= req_wd;
                        if (req_err) begin
                            state      <= S_RESP;
                            req_ack_dm <= 1'b1;
                            err_dm     <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state  <= S_ACCESS;
                            ram_en <= 1'b1;
                            ram_be <= we_dm ? req_be : 4'b0000;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= S_ACCESS;
                        ram_en <= 1'b1;
                        ram_be <= we_q ? be_q : 4'b0000;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    state      <= S_RESP;
                    req_ack_dm <= 1'b1;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Format load data from the RAM word; zero outside a successful load acknowledge.
    always_comb begin
        rd_dm = 32'h0;
        if (req_ack_dm && !err_dm && !we_q) begin
            case (size_q)
                2'd0:    rd_dm = {24'h0, ram_rd[{lane_q, 3'b000} +: 8]};
                2'd1:    rd_dm = {16'h0, (lane_q[1] ? ram_rd[31:16] : ram_rd[15:0])};
                default: rd_dm = ram_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_dm_resp_unit.sv
// Bench for nf_dm_resp_unit: three instances (WAIT_CYCLES 0, 1, 3), each with
// its own synchronous RAM, checked against a byte-addressed memory model.
module tb_nf_dm_resp_unit;

    localparam int ND = 3;

    typedef struct {
        int          en_cnt;
        int          en_cyc;
        int          ack_cnt;
        int          ack_cyc;
        int          rd_leak;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } obs_t;

    typedef struct {
        logic        err;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        err;
        logic [3:0]  be;
        logic [31:0] ram_wd;
        logic [31:0] rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_dm;
    logic [31:0] addr_dm;
    logic [31:0] wd_dm;
    logic [1:0]  size_dm;
    logic        req_v   [ND];
    logic        ack_v   [ND];
    logic [31:0] rd_v    [ND];
    logic        err_v   [ND];
    logic        en_v    [ND];
    logic [3:0]  be_v    [ND];
    logic [31:0] raddr_v [ND];
    logic [31:0] rwd_v   [ND];
    logic [31:0] rrd_v   [ND];
    logic        ram_clr;
    logic [31:0] ram     [ND][16];
    logic [7:0]  mdl     [ND][64];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        nf_dm_resp_unit #(
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) dut (
            .clk       (clk),
            .resetn    (resetn),
            .req_dm    (req_v[g]),
            .we_dm     (we_dm),
            .addr_dm   (addr_dm),
            .wd_dm     (wd_dm),
            .size_dm   (size_dm),
            .req_ack_dm(ack_v[g]),
            .rd_dm     (rd_v[g]),
            .err_dm    (err_v[g]),
            .ram_en    (en_v[g]),
            .ram_be    (be_v[g]),
            .ram_addr  (raddr_v[g]),
            .ram_wd    (rwd_v[g]),
            .ram_rd    (rrd_v[g])
        );
    end

    function automatic int wait_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic logic [7:0] init_byte(int a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [31:0] init_word(int w);
        logic [31:0] v;
        for (int l = 0; l < 4; l++) v[8*l +: 8] = init_byte(4 * w + l);
        return v;
    endfunction

    // Synchronous byte-enabled RAMs, 16 words each; read data appears the cycle after ram_en.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (ram_clr) begin
                for (int w = 0; w < 16; w++) ram[d][w] <= init_word(w);
            end else if (en_v[d]) begin
                for (int l = 0; l < 4; l++)
                    if (be_v[d][l]) ram[d][raddr_v[d][5:2]][8*l +: 8] <= rwd_v[d][8*l +: 8];
                rrd_v[d] <= ram[d][raddr_v[d][5:2]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model: bytes by address; returns expected RAM-side and core-side values.
    function automatic void model_apply(input int d, input logic we, input logic [31:0] addr,
                                        input logic [31:0] wd, input logic [1:0] size,
                                        output exp_t e);
        int n;
        int base;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        e.err  = (n == 0) || ((int'(addr[1:0]) % n) != 0);
        e.addr = {addr[31:2], 2'b00};
        e.be   = 4'b0000;
        e.wd   = 32'h0;
        e.rd   = 32'h0;
        if (!e.err) begin
            base = int'(addr[5:0]);
            for (int i = 0; i < n; i++) begin
                if (we) e.be[int'(addr[1:0]) + i] = 1'b1;
                else    e.rd[8*i +: 8] = mdl[d][base + i];
            end
            for (int l = 0; l < 4; l++) e.wd[8*l +: 8] = wd[8*(l % n) +: 8];
            if (we) for (int i = 0; i < n; i++) mdl[d][base + i] = wd[8*i +: 8];
        end
    endfunction

    // Drive one request on instance d and record what happens, cycle 0 being the sampling edge.
    task automatic run_txn(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] size,
                           input bit scramble, output obs_t o);
        o.en_cnt = 0; o.en_cyc = -1; o.ack_cnt = 0; o.ack_cyc = -1; o.rd_leak = 0;
        o.be = 4'h0; o.addr = 32'h0; o.wd = 32'h0; o.rd = 32'h0; o.err = 1'b0;
        we_dm = we; addr_dm = addr; wd_dm = wd; size_dm = size; req_v[d] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (scramble && k == 1) begin
                addr_dm = ~addr; wd_dm = ~wd; we_dm = ~we; size_dm = size ^ 2'b01;
                req_v[d] = 1'b0;
            end
            if (en_v[d]) begin
                o.en_cnt++; o.en_cyc = k;
                o.be = be_v[d]; o.addr = raddr_v[d]; o.wd = rwd_v[d];
            end
            if (ack_v[d]) begin
                o.ack_cnt++; o.ack_cyc = k; o.rd = rd_v[d]; o.err = err_v[d];
                req_v[d] = 1'b0;
            end else if (rd_v[d] != 32'h0) begin
                o.rd_leak++;
            end
            if (o.ack_cnt > 0 && k >= o.ack_cyc + 2) break;
        end
        req_v[d] = 1'b0;
    endtask

    task automatic check_obs(input string tag, input int d, input logic we,
                             input exp_t e, input obs_t o);
        int w;
        w = wait_of(d);
        check({tag, ".ack_cnt"}, 32'(o.ack_cnt), 32'd1);
        check({tag, ".ack_cyc"}, 32'(o.ack_cyc), e.err ? 32'd1 : 32'(w + 2));
        check({tag, ".err"}, {31'h0, o.err}, {31'h0, e.err});
        check({tag, ".en_cnt"}, 32'(o.en_cnt), e.err ? 32'd0 : 32'd1);
        check({tag, ".rd_leak"}, 32'(o.rd_leak), 32'd0);
        if (!e.err) begin
            check({tag, ".en_cyc"}, 32'(o.en_cyc), 32'(w + 1));
            check({tag, ".be"}, {28'h0, o.be}, {28'h0, e.be});
            check({tag, ".addr"}, o.addr, e.addr);
            if (we) check({tag, ".wd"}, o.wd, e.wd);
            else    check({tag, ".rd"}, o.rd, e.rd);
        end else begin
            check({tag, ".rd_err"}, o.rd, 32'h0);
        end
    endtask

    initial begin
        vec_t        vt[$];
        obs_t        o;
        exp_t        e;
        int          acks;
        int          last_ack;
        int          en_since;
        logic [31:0] b2b_rd;

        resetn = 1'b0; ram_clr = 1'b1;
        we_dm = 1'b0; addr_dm = 32'h0; wd_dm = 32'h0; size_dm = 2'd0;
        for (int d = 0; d < ND; d++) begin
            req_v[d] = 1'b0;
            for (int a = 0; a < 64; a++) mdl[d][a] = init_byte(a);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst%0d.ack", d), {31'h0, ack_v[d]}, 32'h0);
            check($sformatf("rst%0d.err", d), {31'h0, err_v[d]}, 32'h0);
            check($sformatf("rst%0d.en", d), {31'h0, en_v[d]}, 32'h0);
            check($sformatf("rst%0d.be", d), {28'h0, be_v[d]}, 32'h0);
            check($sformatf("rst%0d.rd", d), rd_v[d], 32'h0);
            check($sformatf("rst%0d.addr", d), raddr_v[d], 32'h0);
            check($sformatf("rst%0d.wd", d), rwd_v[d], 32'h0);
        end
        ram_clr = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: instance, we, addr, wd, size, then expected err, be, ram_wd, rd.
        vt.push_back('{1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0});
        vt.push_back('{0, 1'b1, 32'h0000_0100, 32'hA1B2_C3D4, 2'd2, 1'b0, 4'hF, 32'hA1B2_C3D4, 32'h0});
        vt.push_back('{0, 1'b0, 32'h0000_0103, 32'h0,         2'd0, 1'b0, 4'h0, 32'h0,         32'h0000_00A1});
        vt.push_back('{0, 1'b0, 32'h0000_0102, 32'h0,         2'd1, 1'b0, 4'h0, 32'h0,         32'h0000_A1B2});
        vt.push_back('{0, 1'b0, 32'h0000_0100, 32'h0,         2'd1, 1'b0, 4'h0, 32'h0,         32'h0000_C3D4});
        vt.push_back('{0, 1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b0, 4'h0, 32'h0,         32'hA1B2_C3D4});
        vt.push_back('{1, 1'b1, 32'h0000_0102, 32'h0000_1234, 2'd1, 1'b0, 4'hC, 32'h1234_1234, 32'h0});
        vt.push_back('{1, 1'b1, 32'h0000_0101, 32'h0000_1234, 2'd1, 1'b1, 4'h0, 32'h0,         32'h0});
        vt.push_back('{1, 1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b0, 4'h0, 32'h0,         32'h1234_BEEF});
        vt.push_back('{2, 1'b0, 32'h0000_0000, 32'h0,         2'd3, 1'b1, 4'h0, 32'h0,         32'h0});
        vt.push_back('{2, 1'b1, 32'h0000_0202, 32'h5555_AAAA, 2'd2, 1'b1, 4'h0, 32'h0,         32'h0});
        vt.push_back('{1, 1'b1, 32'h0000_0101, 32'hFFFF_FF5A, 2'd0, 1'b0, 4'h2, 32'h5A5A_5A5A, 32'h0});
        vt.push_back('{1, 1'b0, 32'h0000_0101, 32'h0,         2'd0, 1'b0, 4'h0, 32'h0,         32'h0000_005A});

        foreach (vt[i]) begin
            exp_t ev;
            model_apply(vt[i].d, vt[i].we, vt[i].addr, vt[i].wd, vt[i].size, e);
            ev.err = vt[i].err; ev.be = vt[i].be; ev.addr = {vt[i].addr[31:2], 2'b00};
            ev.wd = vt[i].ram_wd; ev.rd = vt[i].rd;
            run_txn(vt[i].d, vt[i].we, vt[i].addr, vt[i].wd, vt[i].size, 1'b0, o);
            check_obs($sformatf("vec%0d", i), vt[i].d, vt[i].we, ev, o);
        end

        // req_dm held high across five word loads on the WAIT_CYCLES=3 instance.
        model_apply(2, 1'b0, 32'h0000_0010, 32'h0, 2'd2, e);
        b2b_rd = e.rd;
        we_dm = 1'b0; addr_dm = 32'h0000_0010; size_dm = 2'd2; req_v[2] = 1'b1;
        acks = 0; last_ack = 0; en_since = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (en_v[2]) en_since++;
            if (ack_v[2]) begin
                acks++;
                check($sformatf("b2b%0d.en_before", acks), 32'(en_since), 32'd1);
                check($sformatf("b2b%0d.rd", acks), rd_v[2], b2b_rd);
                if (acks == 1) check("b2b1.cyc", 32'(k), 32'd5);
                else check($sformatf("b2b%0d.spacing", acks), 32'(k - last_ack), 32'd6);
                last_ack = k; en_since = 0;
                if (acks == 5) req_v[2] = 1'b0;
            end
            if (acks >= 5 && k >= last_ack + 8) break;
        end
        check("b2b.acks", 32'(acks), 32'd5);

        // Reset asserted while instance 1 is in ACCESS and instance 2 is in WAIT.
        we_dm = 1'b1; addr_dm = 32'h0000_0020; wd_dm = 32'hCAFE_F00D; size_dm = 2'd2;
        req_v[1] = 1'b1; req_v[2] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rstmid.en1_before", {31'h0, en_v[1]}, 32'h1);
        check("rstmid.addr2_before", raddr_v[2], 32'h0000_0020);
        #2 resetn = 1'b0;
        #1;
        check("rstmid.en1", {31'h0, en_v[1]}, 32'h0);
        check("rstmid.be1", {28'h0, be_v[1]}, 32'h0);
        check("rstmid.en2", {31'h0, en_v[2]}, 32'h0);
        check("rstmid.addr2", raddr_v[2], 32'h0);
        check("rstmid.wd2", rwd_v[2], 32'h0);
        @(posedge clk);
        #1;
        check("rstmid.ack1", {31'h0, ack_v[1]}, 32'h0);
        check("rstmid.ack2", {31'h0, ack_v[2]}, 32'h0);
        req_v[1] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_apply(2, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2'd2, e);
        run_txn(2, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2'd2, 1'b0, o);
        check_obs("rstnew", 2, 1'b1, e, o);
        model_apply(1, 1'b0, 32'h0000_0020, 32'h0, 2'd2, e);
        run_txn(1, 1'b0, 32'h0000_0020, 32'h0, 2'd2, 1'b0, o);
        check_obs("rstabort_rd1", 1, 1'b0, e, o);
        model_apply(2, 1'b0, 32'h0000_0020, 32'h0, 2'd2, e);
        run_txn(2, 1'b0, 32'h0000_0020, 32'h0, 2'd2, 1'b0, o);
        check_obs("rstnew_rd2", 2, 1'b0, e, o);

        // Inputs changed and req_dm dropped during WAIT.
        model_apply(2, 1'b1, 32'h0000_000C, 32'h1122_3344, 2'd2, e);
        run_txn(2, 1'b1, 32'h0000_000C, 32'h1122_3344, 2'd2, 1'b1, o);
        check_obs("scramble", 2, 1'b1, e, o);

        // Randomized traffic across all three instances.
        for (int i = 0; i < 90; i++) begin
            int          d;
            logic        we;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [1:0]  size;
            d    = $urandom_range(0, ND - 1);
            we   = 1'($urandom);
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            wd   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            model_apply(d, we, addr, wd, size, e);
            run_txn(d, we, addr, wd, size, 1'b0, o);
            check_obs($sformatf("rnd%0d", i), d, we, e, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
